ramp_adc_sequencer: RTL and testbench

Sequencer for the single-slope column ADC: on `start` it clears the per-pixel capture registers, sweeps the shared ramp counter, converts each comparator's first rising edge into a one-cycle capture enable, and then streams the captured codes out pixel by pixel over a valid/ready port. It sits between the comparator bank and the per-pixel register array. It drives that array's `count`, `enable` and clear inputs and reads back the array's `stored_values`.

---
 rtl/adc_pkg.sv | 24 ++
 rtl/comp_edge_sync.sv | 42 ++++
 rtl/ramp_adc_sequencer.sv | 169 ++++++++++++++++
 tb/tb_ramp_adc_sequencer.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : adc_pkg
// Description : Shared types and constants for the ramp ADC sequencer.
//               ADC_SATURATE_EN adds the SAT state to the state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package adc_pkg;

    localparam int DEFAULT_COUNT_WIDTH = 8;
    localparam logic [DEFAULT_COUNT_WIDTH-1:0] COUNT_MAX = '1;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CLEAR   = 3'd1,
        ST_RAMP    = 3'd2,
`ifdef ADC_SATURATE_EN
        ST_SAT     = 3'd3,
`endif
        ST_READOUT = 3'd4
    } adc_seq_state_e;

endpackage : adc_pkg
`default_nettype wire

// File: rtl/comp_edge_sync.sv
`default_nettype none
// ============================================================================
// Module      : comp_edge_sync
// Description : Two-flop synchronizer and rising-edge detect per comparator.
// Revision    : 1.0 - initial release
// ============================================================================
module comp_edge_sync #(
    parameter int NUM_PIXELS = 10
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear,
    input  logic [NUM_PIXELS-1:0] comp,
    output logic [NUM_PIXELS-1:0] rise
);

    logic [NUM_PIXELS-1:0] meta_q;
    logic [NUM_PIXELS-1:0] sync_q;
    logic [NUM_PIXELS-1:0] prev_q;

    // Clearing the whole history makes a comparator that is already high
    // look like a fresh edge once it has crossed the synchronizer again.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta_q <= '0;
            sync_q <= '0;
            prev_q <= '0;
        end else if (clear) begin
            meta_q <= '0;
            sync_q <= '0;
            prev_q <= '0;
        end else begin
            meta_q <= comp;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign rise = sync_q & ~prev_q;

endmodule : comp_edge_sync
`default_nettype wire

// File: rtl/ramp_adc_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : ramp_adc_sequencer
// Description : Single-slope column ADC sequencer: clear, ramp sweep, capture
//               strobes and valid/ready readout. ADC_SATURATE_EN adds SAT.
// Revision    : 1.0 - initial release
// ============================================================================
module ramp_adc_sequencer
    import adc_pkg::*;
#(
    parameter  int NUM_PIXELS  = 10,
    parameter  int COUNT_WIDTH = DEFAULT_COUNT_WIDTH,
    localparam int IDX_WIDTH   = (NUM_PIXELS > 1) ? $clog2(NUM_PIXELS) : 1
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              start,
    input  logic [NUM_PIXELS-1:0]             comp,
    output logic [COUNT_WIDTH-1:0]            count,
    output logic                              ramp_en,
    output logic [NUM_PIXELS-1:0]             enable,
    output logic                              arr_clear,
    input  logic [NUM_PIXELS*COUNT_WIDTH-1:0] stored_values,
    output logic                              rd_valid,
    input  logic                              rd_ready,
    output logic [COUNT_WIDTH-1:0]            rd_data,
    output logic [IDX_WIDTH-1:0]              rd_index,
    output logic                              busy,
    output logic                              done
);

    localparam logic [COUNT_WIDTH-1:0] RAMP_LAST  = '1;
    localparam logic [IDX_WIDTH-1:0]   LAST_INDEX = IDX_WIDTH'(NUM_PIXELS - 1);

    adc_seq_state_e          state_q, state_d;
    logic [COUNT_WIDTH-1:0]  count_q, count_d;
    logic [NUM_PIXELS-1:0]   fired_q, fired_d;
    logic [NUM_PIXELS-1:0]   enable_q, enable_d;
    logic [IDX_WIDTH-1:0]    rd_index_q, rd_index_d;
    logic                    done_d;
    logic                    arr_clear_q, ramp_en_q, rd_valid_q, busy_q, done_q;
    logic                    sync_clear;
    logic [NUM_PIXELS-1:0]   rise;
    logic [COUNT_WIDTH-1:0]  words [NUM_PIXELS];

    comp_edge_sync #(
        .NUM_PIXELS (NUM_PIXELS)
    ) u_comp_edge_sync (
        .clk   (clk),
        .reset (reset),
        .clear (sync_clear),
        .comp  (comp),
        .rise  (rise)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        fired_d    = fired_q;
        rd_index_d = rd_index_q;
        done_d     = 1'b0;
        enable_d   = '0;
        sync_clear = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d    = ST_CLEAR;
                    sync_clear = 1'b1;
                    count_d    = '0;
                    fired_d    = '0;
                end
            end
            ST_CLEAR: begin
                state_d    = ST_RAMP;
                rd_index_d = '0;
            end
            ST_RAMP: begin
                if (count_q == RAMP_LAST) begin
`ifdef ADC_SATURATE_EN
                    state_d = ST_SAT;
`else
                    state_d = ST_READOUT;
`endif
                end else begin
                    count_d = count_q + COUNT_WIDTH'(1);
                end
            end
`ifdef ADC_SATURATE_EN
            ST_SAT: begin
                state_d = ST_READOUT;
            end
`endif
            ST_READOUT: begin
                if (rd_valid_q && rd_ready) begin
                    if (rd_index_q == LAST_INDEX) begin
                        state_d    = ST_IDLE;
                        done_d     = 1'b1;
                        rd_index_d = '0;
                    end else begin
                        rd_index_d = rd_index_q + IDX_WIDTH'(1);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Strobes are gated on the next state so none leak past the ramp.
        if (state_d == ST_RAMP) begin
            enable_d = rise & ~fired_q;
        end
`ifdef ADC_SATURATE_EN
        if (state_d == ST_SAT) begin
            enable_d = ~fired_q;
        end
`endif
        fired_d = fired_d | enable_d;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q     <= '0;
            fired_q     <= '0;
            enable_q    <= '0;
            rd_index_q  <= '0;
            arr_clear_q <= 1'b0;
            ramp_en_q   <= 1'b0;
            rd_valid_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            count_q     <= count_d;
            fired_q     <= fired_d;
            enable_q    <= enable_d;
            rd_index_q  <= rd_index_d;
            arr_clear_q <= (state_d == ST_CLEAR);
            ramp_en_q   <= (state_d == ST_RAMP);
            rd_valid_q  <= (state_d == ST_READOUT);
            busy_q      <= (state_d != ST_IDLE);
            done_q      <= done_d;
        end
    end

    for (genvar i = 0; i < NUM_PIXELS; i++) begin : g_words
        assign words[i] = stored_values[i*COUNT_WIDTH +: COUNT_WIDTH];
    end

    assign count     = count_q;
    assign ramp_en   = ramp_en_q;
    assign enable    = enable_q;
    assign arr_clear = arr_clear_q;
    assign rd_valid  = rd_valid_q;
    assign rd_index  = rd_index_q;
    assign rd_data   = words[rd_index_q];
    assign busy      = busy_q;
    assign done      = done_q;

endmodule : ramp_adc_sequencer
`default_nettype wire

// File: tb/tb_ramp_adc_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_ramp_adc_sequencer
// Description : Self-checking bench with a per-frame first-edge capture model
//               and a behavioural register array. Honours ADC_SATURATE_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ramp_adc_sequencer;
    import adc_pkg::*;

    localparam int N    = 10;
    localparam int W    = 8;
    localparam int IW   = $clog2(N);
    localparam int LAST = (1 << W) - 1;

    logic            clk = 1'b0;
    logic            reset, start, rd_ready;
    logic [N-1:0]    comp, enable;
    logic [W-1:0]    count, rd_data;
    logic            ramp_en, arr_clear, rd_valid, busy, done;
    logic [IW-1:0]   rd_index;
    logic [N*W-1:0]  stored_values;
    logic [W-1:0]    array_q [N];

    int checks = 0;
    int errors = 0;
    int arr_clear_seen = 0;
    int done_seen = 0;
    // wave[p][c+1] is the comparator level during ramp code c; c = -1 is CLEAR
    bit wave [N][LAST+2];

    always #5 clk = ~clk;

    ramp_adc_sequencer #(.NUM_PIXELS(N), .COUNT_WIDTH(W)) dut (
        .clk(clk), .reset(reset), .start(start), .comp(comp), .count(count),
        .ramp_en(ramp_en), .enable(enable), .arr_clear(arr_clear),
        .stored_values(stored_values), .rd_valid(rd_valid), .rd_ready(rd_ready),
        .rd_data(rd_data), .rd_index(rd_index), .busy(busy), .done(done)
    );

    // Behavioural per-pixel register array
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < N; i++) array_q[i] <= '0;
        end else if (arr_clear) begin
            for (int i = 0; i < N; i++) array_q[i] <= '0;
        end else begin
            for (int i = 0; i < N; i++) if (enable[i]) array_q[i] <= count;
        end
    end

    always_comb begin
        stored_values = '0;
        for (int i = 0; i < N; i++) stored_values[i*W +: W] = array_q[i];
    end

    always @(negedge clk) begin
        if (arr_clear === 1'b1) arr_clear_seen <= arr_clear_seen + 1;
        if (done === 1'b1) done_seen <= done_seen + 1;
    end

    function automatic void clear_wave();
        for (int p = 0; p < N; p++)
            for (int c = 0; c < LAST + 2; c++) wave[p][c] = 1'b0;
    endfunction

    function automatic void set_step(input int p, input int c0);
        for (int c = c0; c <= LAST; c++) wave[p][c+1] = 1'b1;
    endfunction

    function automatic void fill_random();
        clear_wave();
        for (int p = 0; p < N; p++) begin
            case ($urandom_range(0, 3))
                0: ;
                1: set_step(p, int'($urandom_range(0, 257)) - 1);
                2: begin
                    int c0 = int'($urandom_range(0, 250));
                    set_step(p, c0);
                    wave[p][c0+2] = 1'b0;
                end
                default: for (int c = 0; c < LAST + 2; c++) wave[p][c] = 1'($urandom_range(0, 1));
            endcase
        end
    endfunction

    // Capture = first rising code + 3 pipeline stages, if it lands inside the ramp.
    function automatic void model(input int p, output logic [W-1:0] code, output int pulses);
        int first = -2;
        for (int c = -1; c <= LAST; c++) begin
            bit prv = (c == -1) ? 1'b0 : wave[p][c];
            if (wave[p][c+1] && !prv) begin
                first = c;
                break;
            end
        end
        if (first != -2 && first + 3 <= LAST) begin
            code = W'(first + 3);
            pulses = 1;
        end else begin
`ifdef ADC_SATURATE_EN
            code = COUNT_MAX;
            pulses = 1;
`else
            code = '0;
            pulses = 0;
`endif
        end
    endfunction

    task automatic run_frame(input string tag, input int extra_start_c,
                             input int stall0, input int stall1, input int stall_len);
        logic [W-1:0] exp_code [N];
        int exp_pulses [N];
        int pulses [N];
        int bad_ramp = 0;
        int clr0 = arr_clear_seen;
        int done0 = done_seen;
        for (int p = 0; p < N; p++) begin
            model(p, exp_code[p], exp_pulses[p]);
            pulses[p] = 0;
            comp[p] = wave[p][0];
        end
        rd_ready = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (!(busy === 1'b1 && arr_clear === 1'b1 && ramp_en === 1'b0 && count === '0 && enable === '0)) begin
            errors++;
            $display("FAIL %s clear_cycle: busy=%b arr_clear=%b ramp_en=%b count=%0d enable=%b, required 1 1 0 0 0",
                     tag, busy, arr_clear, ramp_en, count, enable);
        end
        for (int c = 0; c <= LAST; c++) begin
            @(negedge clk);
            start = (c == extra_start_c);
            if (count !== W'(c) || ramp_en !== 1'b1 || busy !== 1'b1 || arr_clear !== 1'b0 || rd_valid !== 1'b0)
                bad_ramp++;
            for (int p = 0; p < N; p++) begin
                if (enable[p]) pulses[p]++;
                comp[p] = wave[p][c+1];
            end
        end
        start = 1'b0;
        checks++;
        if (bad_ramp !== 0) begin
            errors++;
            $display("FAIL %s ramp_sweep: %0d bad ramp cycles, required 0", tag, bad_ramp);
        end
`ifdef ADC_SATURATE_EN
        @(negedge clk);
        for (int p = 0; p < N; p++) if (enable[p]) pulses[p]++;
        checks++;
        if (count !== W'(LAST) || ramp_en !== 1'b0 || busy !== 1'b1 || rd_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s sat_cycle: count=%0d ramp_en=%b busy=%b rd_valid=%b, required %0d 0 1 0",
                     tag, count, ramp_en, busy, rd_valid, LAST);
        end
`endif
        for (int w = 0; w < N; w++) begin
            int stall = (w == stall0 || w == stall1) ? stall_len : 0;
            for (int s = 0; s <= stall; s++) begin
                @(negedge clk);
                for (int p = 0; p < N; p++) if (enable[p]) pulses[p]++;
                checks++;
                if (rd_valid !== 1'b1 || rd_index !== IW'(w) || rd_data !== exp_code[w] || done !== 1'b0) begin
                    errors++;
                    $display("FAIL %s readout word %0d stall %0d: valid=%b index=%0d data=%0d done=%b, required 1 %0d %0d 0",
                             tag, w, s, rd_valid, rd_index, rd_data, done, w, exp_code[w]);
                end
                rd_ready = (s == stall);
            end
        end
        @(negedge clk);
        rd_ready = 1'b0;
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || rd_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s done_pulse: done=%b busy=%b rd_valid=%b, required 1 0 0", tag, done, busy, rd_valid);
        end
        for (int p = 0; p < N; p++) begin
            checks++;
            if (pulses[p] != exp_pulses[p]) begin
                errors++;
                $display("FAIL %s enable_pulses pixel %0d: got %0d, required %0d", tag, p, pulses[p], exp_pulses[p]);
            end
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || done_seen - done0 != 1 || arr_clear_seen - clr0 != 1) begin
            errors++;
            $display("FAIL %s frame_pulses: done=%b done_pulses=%0d arr_clear_pulses=%0d, required 0 1 1",
                     tag, done, done_seen - done0, arr_clear_seen - clr0);
        end
    endtask

    task automatic test_reset;
        reset = 1'b1; start = 1'b0; rd_ready = 1'b0; comp = '0;
        repeat (3) @(negedge clk);
        checks++; if (count !== '0) begin errors++; $display("FAIL reset count: got %0d, required 0", count); end
        checks++; if (enable !== '0) begin errors++; $display("FAIL reset enable: got %b, required 0", enable); end
        checks++; if (arr_clear !== 1'b0) begin errors++; $display("FAIL reset arr_clear: got %b, required 0", arr_clear); end
        checks++; if (ramp_en !== 1'b0) begin errors++; $display("FAIL reset ramp_en: got %b, required 0", ramp_en); end
        checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL reset rd_valid: got %b, required 0", rd_valid); end
        checks++; if (rd_index !== '0) begin errors++; $display("FAIL reset rd_index: got %0d, required 0", rd_index); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset busy: got %b, required 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset done: got %b, required 0", done); end
        reset = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_hold busy: got %b, required 0", busy); end
    endtask

    task automatic test_basic_capture;
        clear_wave();
        set_step(0, 10);
        set_step(1, 200);
        run_frame("basic", -1, -1, -1, 0);
    endtask

    task automatic test_glitch;
        clear_wave();
        set_step(2, 50);
        wave[2][52] = 1'b0;
        run_frame("glitch", -1, -1, -1, 0);
    endtask

    task automatic test_prehigh;
        clear_wave();
        for (int p = 0; p < N; p++) set_step(p, -1);
        run_frame("prehigh", -1, -1, -1, 0);
    endtask

    task automatic test_backpressure;
        fill_random();
        run_frame("backpressure", -1, 0, 3, 5);
    endtask

    task automatic test_ignored_start_and_reset;
        fill_random();
        run_frame("extra_start", int'($urandom_range(20, 200)), -1, -1, 0);
        comp = '1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (101) @(negedge clk);
        checks++;
        if (count !== W'(100)) begin
            errors++;
            $display("FAIL midramp_position: count=%0d, required 100", count);
        end
        reset = 1'b1;
        #1;
        checks++;
        if (count !== '0 || enable !== '0 || arr_clear !== 1'b0 || ramp_en !== 1'b0 || rd_valid !== 1'b0 ||
            rd_index !== '0 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL midramp_reset outputs: count=%0d enable=%b arr_clear=%b ramp_en=%b rd_valid=%b rd_index=%0d busy=%b done=%b, required all 0",
                     count, enable, arr_clear, ramp_en, rd_valid, rd_index, busy, done);
        end
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || ramp_en !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_idle: busy=%b ramp_en=%b, required 0 0", busy, ramp_en);
        end
        fill_random();
        run_frame("after_reset", -1, -1, -1, 0);
    endtask

    task automatic test_back_to_back;
        clear_wave();
        for (int p = 0; p < N; p++) set_step(p, int'($urandom_range(0, 200)));
        run_frame("b2b_first", -1, -1, -1, 0);
        clear_wave();
        for (int p = 0; p < N; p++) if ($urandom_range(0, 1) == 1) set_step(p, int'($urandom_range(0, 252)));
        run_frame("b2b_second", -1, -1, -1, 0);
    endtask

    task automatic test_random;
        for (int f = 0; f < 3; f++) begin
            fill_random();
            run_frame("random", -1, int'($urandom_range(0, N - 1)), -1, int'($urandom_range(1, 3)));
        end
    endtask

    initial begin
        test_reset();
        test_basic_capture();
        test_glitch();
        test_prehigh();
        test_backpressure();
        test_ignored_start_and_reset();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_ramp_adc_sequencer
`default_nettype wire
